// File: rtl/fpu_pkg.sv
// Shared FPU definitions: operand type, op codes, the canonical quiet NaN,
// and the sequencer state encoding.
package fpu_pkg;

    typedef logic [31:0] fp32_t;

    localparam logic  OP_ADD  = 1'b0;
    localparam logic  OP_SUB  = 1'b1;
    localparam fp32_t FP_QNAN = 32'h7FC00000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/rr_grant.sv
// Combinational round-robin picker: grants the first set request at or after
// ptr_i, scanning upward and wrapping. any_o flags that a grant was made.
module rr_grant #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    output logic [N-1:0]         gnt_o,
    output logic [$clog2(N)-1:0] idx_o,
    output logic                 any_o
);

    localparam int             IW   = $clog2(N);
    localparam logic [IW-1:0]  LAST = IW'(N - 1);

    logic [IW-1:0] scan;

    // Walk the ring once from the pointer; the first hit wins.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        scan  = ptr_i;
        for (int k = 0; k < N; k++) begin
            if (!any_o && req_i[scan]) begin
                any_o       = 1'b1;
                idx_o       = scan;
                gnt_o[scan] = 1'b1;
            end
            scan = (scan == LAST) ? '0 : scan + 1'b1;
        end
    end

endmodule

// File: rtl/fpu_sp_arbiter.sv
// Round-robin sequencer sharing one add and one sub unit among N_REQ
// requesters. One operation in flight: grant, issue pulse, wait for rdy under a
// watchdog, then broadcast a tagged response.
//
// Handshakes: a requester holds req_valid and operands until its req_ready bit
// is seen (combinational, one-hot, only in IDLE). Units receive a one-cycle
// dval pulse and answer with rdy, sampled only while waiting. resp_valid is a
// one-cycle strobe with no backpressure.
module fpu_sp_arbiter
    import fpu_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 64,
    parameter int ID_W    = $clog2(N_REQ)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [N_REQ-1:0]    req_op,
    input  logic [N_REQ*32-1:0] req_a,
    input  logic [N_REQ*32-1:0] req_b,
    output logic [N_REQ-1:0]    req_ready,
    output logic                resp_valid,
    output logic [ID_W-1:0]     resp_id,
    output logic [31:0]         resp_data,
    output logic                resp_err,
    output logic                fpu_rst_n,
    output logic [31:0]         fpu_din1,
    output logic [31:0]         fpu_din2,
    output logic                fpu_dval_add,
    output logic                fpu_dval_sub,
    input  logic                fpu_rdy_add,
    input  logic                fpu_rdy_sub,
    input  logic [31:0]         fpu_res_add,
    input  logic [31:0]         fpu_res_sub,
    output logic [1:0]          dbg_state
);

    localparam int CNT_W = $clog2(TIMEOUT);

    arb_state_e        state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic              op_q, op_d;
    fp32_t             din1_q, din1_d;
    fp32_t             din2_q, din2_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              dval_add_q, dval_add_d;
    logic              dval_sub_q, dval_sub_d;
    logic              resp_valid_q, resp_valid_d;
    logic [ID_W-1:0]   resp_id_q, resp_id_d;
    fp32_t             resp_data_q, resp_data_d;
    logic              resp_err_q, resp_err_d;
    // Holds off grants for the first cycle after reset.
    logic              boot_q;

    logic [N_REQ-1:0]  gnt;
    logic [ID_W-1:0]   gnt_idx;
    logic              gnt_any;
    logic              grant_en;
    logic              sel_op;
    fp32_t             sel_a, sel_b;
    logic              rdy_sel;
    fp32_t             res_sel;

    rr_grant #(.N(N_REQ)) u_rr_grant (
        .req_i (req_valid),
        .ptr_i (rr_ptr_q),
        .gnt_o (gnt),
        .idx_o (gnt_idx),
        .any_o (gnt_any)
    );

    assign grant_en  = (state_q == IDLE) && !rst && !boot_q;
    assign req_ready = grant_en ? gnt : '0;
    assign rdy_sel   = (op_q == OP_SUB) ? fpu_rdy_sub : fpu_rdy_add;
    assign res_sel   = (op_q == OP_SUB) ? fpu_res_sub : fpu_res_add;

    // Pull the granted requester's op and operands out of the packed buses.
    always_comb begin
        sel_op = 1'b0;
        sel_a  = '0;
        sel_b  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                sel_op = req_op[i];
                sel_a  = req_a[32*i +: 32];
                sel_b  = req_b[32*i +: 32];
            end
        end
    end

    // Sequencer next-state and registered-output next values.
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        id_d         = id_q;
        op_d         = op_q;
        din1_d       = din1_q;
        din2_d       = din2_q;
        cnt_d        = cnt_q;
        dval_add_d   = 1'b0;
        dval_sub_d   = 1'b0;
        resp_valid_d = 1'b0;
        resp_id_d    = resp_id_q;
        resp_data_d  = resp_data_q;
        resp_err_d   = resp_err_q;
        case (state_q)
            IDLE: begin
                if (grant_en && gnt_any) begin
                    din1_d     = sel_a;
                    din2_d     = sel_b;
                    op_d       = sel_op;
                    id_d       = gnt_idx;
                    rr_ptr_d   = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                    // Pulse lands in the ISSUE cycle.
                    dval_add_d = (sel_op == OP_ADD);
                    dval_sub_d = (sel_op == OP_SUB);
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // rdy beats the watchdog when both happen on the same cycle.
                if (rdy_sel) begin
                    resp_data_d = res_sel;
                    resp_err_d  = 1'b0;
                    state_d     = RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    resp_data_d = FP_QNAN;
                    resp_err_d  = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                resp_valid_d = 1'b1;
                resp_id_d    = id_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            id_q         <= '0;
            op_q         <= 1'b0;
            din1_q       <= '0;
            din2_q       <= '0;
            cnt_q        <= '0;
            dval_add_q   <= 1'b0;
            dval_sub_q   <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
            boot_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            id_q         <= id_d;
            op_q         <= op_d;
            din1_q       <= din1_d;
            din2_q       <= din2_d;
            cnt_q        <= cnt_d;
            dval_add_q   <= dval_add_d;
            dval_sub_q   <= dval_sub_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
            boot_q       <= 1'b0;
        end
    end

    // A timed-out unit is flushed during the RESP cycle.
    assign fpu_rst_n    = ~rst & ~((state_q == RESP) & resp_err_q);
    assign fpu_din1     = din1_q;
    assign fpu_din2     = din2_q;
    assign fpu_dval_add = dval_add_q;
    assign fpu_dval_sub = dval_sub_q;
    assign resp_valid   = resp_valid_q;
    assign resp_id      = resp_id_q;
    assign resp_data    = resp_data_q;
    assign resp_err     = resp_err_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_fpu_sp_arbiter.sv
// Bench for fpu_sp_arbiter: behavioural arbitration/latency model, unit mocks,
// expected-response queue with a separate monitor.
module tb_fpu_sp_arbiter;
  import fpu_pkg::*;

  localparam int N_REQ   = 4;
  localparam int TIMEOUT = 8;
  localparam int ID_W    = 2;
  localparam int NEVER   = 1000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [N_REQ-1:0]    req_valid = '0;
  logic [N_REQ-1:0]    req_op = '0;
  logic [N_REQ*32-1:0] req_a = '0;
  logic [N_REQ*32-1:0] req_b = '0;
  logic [N_REQ-1:0]    req_ready;
  logic                resp_valid;
  logic [ID_W-1:0]     resp_id;
  logic [31:0]         resp_data;
  logic                resp_err;
  logic                fpu_rst_n;
  logic [31:0]         fpu_din1, fpu_din2;
  logic                fpu_dval_add, fpu_dval_sub;
  logic                fpu_rdy_add = 1'b0, fpu_rdy_sub = 1'b0;
  logic [31:0]         fpu_res_add = '0, fpu_res_sub = '0;
  logic [1:0]          dbg_state;

  fpu_sp_arbiter #(.N_REQ(N_REQ), .TIMEOUT(TIMEOUT), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data), .resp_err(resp_err),
    .fpu_rst_n(fpu_rst_n), .fpu_din1(fpu_din1), .fpu_din2(fpu_din2),
    .fpu_dval_add(fpu_dval_add), .fpu_dval_sub(fpu_dval_sub),
    .fpu_rdy_add(fpu_rdy_add), .fpu_rdy_sub(fpu_rdy_sub),
    .fpu_res_add(fpu_res_add), .fpu_res_sub(fpu_res_sub),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic [31:0]     cyc;
    logic [ID_W-1:0] id;
    logic            err;
    logic [31:0]     data;
  } exp_t;
  exp_t exp_q[$];

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Knobs written only by the main sequence.
  int fixed_lat = 2;        // <0 selects random latency
  bit auto_en = 0, hold_all = 0, noise_en = 0, issue_noise = 0;
  int late_cyc = -1;
  int dir_seq[N_REQ];
  logic dir_op[N_REQ];
  logic [31:0] dir_a[N_REQ], dir_b[N_REQ];

  // Written only by the monitor.
  int m_ptr = 0, m_free = 0, cur_lat = 1;
  int dval_cyc = -1, flush_cyc = -1, fire_cyc = -1;
  logic dval_op = 1'b0, fire_op = 1'b0;
  logic [31:0] fire_res = '0, exp_din1 = '0, exp_din2 = '0;
  int gnt_count[N_REQ];
  int grant_log[$];
  bit prev_rst = 0;

  // Unit behaviour: the two spec vectors, integer arithmetic otherwise.
  function automatic logic [31:0] unit_res(input logic op, input logic [31:0] a, input logic [31:0] b);
    if (op == OP_ADD && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
    if (op == OP_SUB && a == 32'h422E3333 && b == 32'h428A3D71) return 32'hC1CC8F5E;
    return (op == OP_SUB) ? a - b : a + b;
  endfunction

  // Reference arbitration: first valid at or after ptr, with wrap.
  function automatic int pick(input logic [N_REQ-1:0] v, input int ptr);
    for (int k = 0; k < N_REQ; k++)
      if (v[(ptr + k) % N_REQ]) return (ptr + k) % N_REQ;
    return -1;
  endfunction

  // ---------------- monitor + model ----------------
  always @(negedge clk) begin
    int g, lat, eff, dut_g;
    logic err, op;
    logic [31:0] a, b;
    exp_t e;
    if (rst) begin
      chk("rst_req_ready", {28'd0, req_ready}, 32'd0);
      chk("rst_fpu_rst_n", {31'd0, fpu_rst_n}, 32'd0);
      exp_q.delete();
      m_ptr = 0; m_free = cyc + 2;
      dval_cyc = -1; flush_cyc = -1; fire_cyc = -1;
      exp_din1 = '0; exp_din2 = '0;
    end else begin
      if (prev_rst) begin
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_id", {30'd0, resp_id}, 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
      end
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL resp_unexpected cyc=%0d actual id=%0d data=%h expected no response", cyc, resp_id, resp_data);
        end else begin
          e = exp_q.pop_front();
          chk("resp_cycle", cyc, e.cyc);
          chk("resp_id", {30'd0, resp_id}, {30'd0, e.id});
          chk("resp_data", resp_data, e.data);
          chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
        end
      end else if (exp_q.size() > 0 && int'(exp_q[0].cyc) < cyc) begin
        e = exp_q.pop_front();
        tests++; fails++;
        $display("FAIL resp_missing cyc=%0d actual none expected id=%0d at cyc=%0d", cyc, e.id, e.cyc);
      end
      chk("dval_add", {31'd0, fpu_dval_add}, {31'd0, (cyc == dval_cyc && dval_op == OP_ADD)});
      chk("dval_sub", {31'd0, fpu_dval_sub}, {31'd0, (cyc == dval_cyc && dval_op == OP_SUB)});
      chk("din1", fpu_din1, exp_din1);
      chk("din2", fpu_din2, exp_din2);
      chk("fpu_rst_n", {31'd0, fpu_rst_n}, {31'd0, (cyc != flush_cyc)});
      chk("ready_onehot", {31'd0, $onehot0(req_ready)}, 32'd1);
      // Unit mock: arm the result when the issue pulse is seen.
      if (fpu_dval_add || fpu_dval_sub) begin
        fire_cyc = cyc + cur_lat;
        fire_op  = fpu_dval_sub;
        fire_res = unit_res(fpu_dval_sub, fpu_din1, fpu_din2);
      end
      if (!fpu_rst_n) fire_cyc = -1;
      // Arbitration model.
      g = (cyc >= m_free) ? pick(req_valid, m_ptr) : -1;
      chk("req_ready", {28'd0, req_ready}, (g >= 0) ? (32'd1 << g) : 32'd0);
      if (req_ready != '0) begin
        dut_g = 0;
        for (int i = 0; i < N_REQ; i++) if (req_ready[i]) dut_g = i;
        grant_log.push_back(dut_g);
      end
      if (g >= 0) begin
        gnt_count[g]++;
        if (fixed_lat >= 0) lat = fixed_lat;
        else lat = ($urandom_range(0, 9) == 0) ? NEVER : $urandom_range(1, TIMEOUT + 2);
        cur_lat = lat;
        op  = req_op[g];
        a   = req_a[32*g +: 32];
        b   = req_b[32*g +: 32];
        err = (lat > TIMEOUT);
        eff = err ? TIMEOUT : lat;
        e.cyc  = cyc + 3 + eff;
        e.id   = ID_W'(g);
        e.err  = err;
        e.data = err ? FP_QNAN : unit_res(op, a, b);
        exp_q.push_back(e);
        dval_cyc  = cyc + 1;
        dval_op   = op;
        exp_din1  = a;
        exp_din2  = b;
        flush_cyc = err ? cyc + 2 + eff : -1;
        m_ptr     = (g + 1) % N_REQ;
        m_free    = cyc + 3 + eff;
      end
    end
    prev_rst = rst;
  end

  // ---------------- unit mocks ----------------
  always @(posedge clk) begin
    #1;
    fpu_rdy_add = 1'b0; fpu_rdy_sub = 1'b0;
    fpu_res_add = $urandom; fpu_res_sub = $urandom;
    if (fire_cyc == cyc) begin
      if (fire_op) begin fpu_rdy_sub = 1'b1; fpu_res_sub = fire_res; end
      else begin fpu_rdy_add = 1'b1; fpu_res_add = fire_res; end
    end else if (cyc == dval_cyc && issue_noise) begin
      if (dval_op) fpu_rdy_sub = 1'b1; else fpu_rdy_add = 1'b1;
    end
    // The non-selected unit chatters freely.
    if (noise_en && $urandom_range(0, 2) == 0) begin
      if (dval_op) fpu_rdy_add = 1'b1; else fpu_rdy_sub = 1'b1;
    end
    if (cyc == late_cyc) begin fpu_rdy_add = 1'b1; fpu_rdy_sub = 1'b1; end
  end

  // ---------------- requester driver ----------------
  int gnt_done[N_REQ];
  int dir_done[N_REQ];
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_count[i] != gnt_done[i]) begin
        gnt_done[i] = gnt_count[i];
        req_valid[i] = 1'b0;
      end
      if (dir_seq[i] != dir_done[i]) begin
        dir_done[i] = dir_seq[i];
        req_op[i] = dir_op[i];
        req_a[32*i +: 32] = dir_a[i];
        req_b[32*i +: 32] = dir_b[i];
        req_valid[i] = 1'b1;
      end else if (!req_valid[i] && (hold_all || (auto_en && $urandom_range(0, 3) == 0))) begin
        req_op[i] = 1'($urandom_range(0, 1));
        req_a[32*i +: 32] = $urandom;
        req_b[32*i +: 32] = $urandom;
        req_valid[i] = 1'b1;
      end else if (req_valid[i] && auto_en && $urandom_range(0, 19) == 0) begin
        req_valid[i] = 1'b0;   // legal withdrawal before grant
      end
    end
  end

  task automatic send(input int i, input logic op, input logic [31:0] a, input logic [31:0] b);
    dir_op[i] = op; dir_a[i] = a; dir_b[i] = b;
    dir_seq[i]++;
  endtask

  task automatic wait_drain(input int bound);
    int n = 0;
    repeat (2) @(posedge clk);
    while ((exp_q.size() > 0 || req_valid != '0) && n < bound) begin
      @(posedge clk); n++;
    end
    if (n >= bound) begin
      tests++; fails++;
      $display("FAIL drain_timeout cyc=%0d actual pending=%0d expected 0", cyc, exp_q.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n, base;
    // Fairness: every requester holds valid from reset.
    hold_all = 1; fixed_lat = -1;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    n = 0;
    while (grant_log.size() < 8 && n < 400) begin @(posedge clk); n++; end
    #1 hold_all = 0;
    chk("fair_grants_seen", {31'd0, grant_log.size() >= 8}, 32'd1);
    for (int k = 0; k < 8 && k < grant_log.size(); k++) chk("fair_order", grant_log[k], k % 4);
    wait_drain(300);

    // Single add, L = 3: response 6 cycles after grant (checked by the queue).
    fixed_lat = 3;
    send(1, OP_ADD, 32'h3F800000, 32'h40000000);
    wait_drain(100);

    // Single sub.
    fixed_lat = 2;
    send(0, OP_SUB, 32'h422E3333, 32'h428A3D71);
    wait_drain(100);

    // Timeout: unit never answers.
    fixed_lat = NEVER;
    send(2, OP_ADD, 32'h11111111, 32'h22222222);
    wait_drain(100);

    // Boundary: rdy on the last WAIT cycle, with rdy also high during ISSUE.
    issue_noise = 1;
    fixed_lat = TIMEOUT;
    send(3, OP_SUB, 32'h00000050, 32'h00000010);
    wait_drain(100);
    fixed_lat = 1;
    send(2, OP_ADD, 32'h12345678, 32'h00000001);
    wait_drain(100);
    fixed_lat = 4;
    send(1, OP_SUB, 32'hCAFEF00D, 32'h0000000D);
    wait_drain(100);

    // Random traffic with chatter on the idle unit.
    fixed_lat = -1; noise_en = 1; auto_en = 1;
    repeat (1500) @(posedge clk);
    #1 auto_en = 0;
    wait_drain(2000);
    noise_en = 0; issue_noise = 0;

    // Reset in the middle of WAIT, then a stray rdy.
    fixed_lat = 20;
    base = grant_log.size();
    send(1, OP_SUB, 32'h00000001, 32'h00000002);
    n = 0;
    while (grant_log.size() == base && n < 50) begin @(posedge clk); n++; end
    chk("midwait_granted", {31'd0, grant_log.size() > base}, 32'd1);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    late_cyc = cyc + 3;
    repeat (10) @(posedge clk);
    #1;
    // Pointer must be back at 0: 0 is served before 2.
    fixed_lat = 2;
    base = grant_log.size();
    send(0, OP_ADD, 32'h00000003, 32'h00000004);
    send(2, OP_ADD, 32'h00000005, 32'h00000006);
    wait_drain(100);
    chk("post_rst_grants", grant_log.size(), base + 2);
    if (grant_log.size() >= base + 2) begin
      chk("post_rst_first", grant_log[base], 0);
      chk("post_rst_second", grant_log[base + 1], 2);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout cyc=%0d actual running expected finished", cyc);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/fpu_sp_arbiter.md
# fpu_sp_arbiter

Round-robin arbiter and sequencer that shares one single-precision add unit and one subtract unit (dval/rdy handshake, variable latency) among N_REQ requesters. It accepts one operation at a time, issues a one-cycle dval pulse to the selected unit, and waits for rdy under a watchdog. It then broadcasts a tagged response. It sits between the core-side requesters and the fpu_sp_add / fpu_sp_sub instances.

## Interface
- N_REQ, 4, number of requesters (2..8)
- TIMEOUT, 64, max cycles in WAIT before a forced error response (≥2)
- ID_W, $clog2(N_REQ), response tag width
- clk  in  1  clock; all logic rising-edge
- rst  in  1  synchronous reset, active-high
- req_valid  in  N_REQ  per-requester request valid
- req_op  in  N_REQ  per-requester op: 0 = add, 1 = sub
- req_a  in  N_REQ*32  operand A, requester i at [32i+31:32i]
- req_b  in  N_REQ*32  operand B, same packing
- req_ready  out  N_REQ  one-hot accept strobe; at most one bit set
- resp_valid  out  1  one-cycle response strobe
- resp_id  out  ID_W  index of the requester the response belongs to
- resp_data  out  32  result, IEEE-754 single
- resp_err  out  1  watchdog expired; resp_data = 32'h7FC00000
- fpu_rst_n  out  1  active-low reset to both FPU units
- fpu_din1, fpu_din2  out  32  registered operands shared by both units
- fpu_dval_add, fpu_dval_sub  out  1  one-cycle issue pulse to the selected unit
- fpu_rdy_add, fpu_rdy_sub  in  1  unit result ready
- fpu_res_add, fpu_res_sub  in  32  unit results

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset state is IDLE.
- IDLE:
  - When no req_valid bit is set, stay in IDLE.
  - Otherwise grant the first set bit at or after rr_ptr, scanning upward with wrap.
  - Assert req_ready[g] combinationally in the same cycle.
  - Latch the operands into fpu_din1/fpu_din2, latch the op, and set id = g.
  - Set rr_ptr = (g+1) mod N_REQ. Next state is ISSUE.
- ISSUE: assert fpu_dval_add if op = 0, else fpu_dval_sub, for exactly one cycle. Clear the watchdog counter. Next state is WAIT.
- WAIT:
  - Sample only the rdy of the selected unit; the other unit's rdy is ignored.
  - If it is high, capture that unit's result into resp_data, clear resp_err, and go to RESP.
  - Otherwise increment the counter. When the counter reaches TIMEOUT-1 with rdy still low, set resp_data = 32'h7FC00000, set resp_err = 1, and go to RESP.
- RESP:
  - resp_valid = 1 for one cycle, with resp_id = id.
  - If resp_err, drive fpu_rst_n low for this cycle to flush the stuck unit.
  - Next state is IDLE.
- Responses have no backpressure. Every requester must monitor resp_valid/resp_id.
- A requester must hold valid and operands stable until it sees its req_ready bit. Dropping valid before the grant withdraws the request and is legal.
- fpu_din1/fpu_din2 hold their values from the grant until the next grant.

## Timing
- Reset values while rst is high, and on the first cycle after it:
  - req_ready = 0, resp_valid = 0, resp_id = 0, resp_data = 0, resp_err = 0.
  - fpu_dval_* = 0, fpu_din* = 0.
  - rr_ptr = 0, counter = 0, state = IDLE.
  - fpu_rst_n = 0 (combinational ~rst, ANDed with the RESP flush term).
- Reset in any state aborts the operation with no response. A rdy arriving later is ignored because the state is IDLE.
- Latency: with unit latency L, resp_valid is high 2+L+1 cycles after the grant cycle. Here L counts cycles from the dval pulse to the first rdy-high sample in WAIT (L ≥ 1).
- Throughput is one operation per L+3 cycles. A new grant is possible in the cycle after RESP.
- rdy high in the ISSUE cycle is ignored; only WAIT samples rdy.
- If rdy is high on the cycle the counter hits TIMEOUT-1, rdy wins and resp_err = 0.
- All outputs are registered except req_ready and fpu_rst_n.

## Structure
- Shared package fpu_pkg holds:
  - typedef fp32_t (32-bit).
  - localparams OP_ADD = 0, OP_SUB = 1.
  - FP_QNAN = 32'h7FC00000.
  - state enum {IDLE, ISSUE, WAIT, RESP}.
- Sub-module rr_grant (parameter N): combinational round-robin picker. Inputs are req[N] and ptr; outputs are a one-hot grant and the encoded index. It is reusable by later FPU schedulers.
- The FPU units are instantiated outside this block.

## Test plan
- Single add: requester 1 sends 3F800000 + 40000000 with a unit of L = 3. Expect resp_valid 6 cycles after the grant, resp_id = 1, resp_data = 40400000, resp_err = 0.
- Single sub: requester 0 sends 422E3333 − 428A3D71. Expect fpu_dval_sub pulsed, fpu_dval_add silent, resp_data = C1CC8F5E.
- Fairness: all 4 requesters hold valid from reset. Grant order is 0,1,2,3,0,…; each resp_id matches its grant, and req_ready stays one-hot.
- Timeout: the unit never raises rdy and TIMEOUT = 8. Expect resp_err = 1 and resp_data = 7FC00000 exactly 8 WAIT cycles after ISSUE, with fpu_rst_n low in the RESP cycle only.
- Boundary: rdy rises on the last WAIT cycle. Expect a normal result with resp_err = 0. Separately, rdy held high during ISSUE is ignored.
- Reset mid-WAIT: assert rst for 1 cycle. Expect no resp_valid, all outputs at reset values, rr_ptr = 0; a later rdy pulse produces no response.
